acc_cpu_gen2: RTL

ACC_CPU_GEN2 -- requirements
Module: acc_cpu_gen2

---
 rtl/acc_cpu_gen2.sv | 325 ++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/acc_cpu_gen2.sv
// acc_cpu_gen2 -- multi-cycle accumulator CPU with a request/acknowledge memory port.
// Instruction word: opcode [15:12], mode [11:10], operand [9:0].
// Optional feature: define ACC_CPU_GEN2_CALL_EN to enable CALL/RET and the return
// stack. Without it, opcodes C and D trap and no stack storage exists.
module acc_cpu_gen2 #(
  parameter int WIDTH       = 16,
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  input  logic              run,
  output logic              busy,
  output logic              halt,
  output logic              trap,
  output logic [7:0]        data_out,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_OPER, S_PTR, S_WRITE, S_HALT, S_TRAP
  } state_t;

  localparam logic [3:0] OP_NOP = 4'h0, OP_LOAD = 4'h1, OP_STORE = 4'h2, OP_ADD = 4'h3,
                         OP_SUB = 4'h4, OP_AND = 4'h5, OP_OR = 4'h6, OP_XOR = 4'h7,
                         OP_NOT = 4'h8, OP_BR = 4'h9, OP_IF = 4'hA, OP_OUT = 4'hB,
                         OP_CALL = 4'hC, OP_RET = 4'hD, OP_HALT = 4'hE;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [WIDTH-1:0]    accum_q, accum_d;
  logic                z_q, z_d, c_q, c_d, skip_q, skip_d;
  logic [7:0]          data_out_q, data_out_d;
  logic                mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WIDTH-1:0]    mem_wdata_q, mem_wdata_d;
  logic [15:0]         ir_q, ir_d;

  // ALU: returns {carry/borrow, result}; carry is passed through for logic ops
  function automatic logic [WIDTH:0] alu(input logic [3:0] op, input logic [WIDTH-1:0] a,
                                         input logic [WIDTH-1:0] b, input logic c_in);
    logic [WIDTH:0] r;
    r = {c_in, a};
    case (op)
      OP_LOAD: r = {c_in, b};
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {c_in, a & b};
      OP_OR:   r = {c_in, a | b};
      OP_XOR:  r = {c_in, a ^ b};
      OP_NOT:  r = {c_in, ~a};
      default: r = {c_in, a};
    endcase
    return r;
  endfunction

  // Zero-extend the 10-bit operand to a memory address
  function automatic logic [ADDR_W-1:0] opnd_addr(input logic [9:0] o);
    logic [ADDR_W+9:0] t;
    t = {{ADDR_W{1'b0}}, o};
    return t[ADDR_W-1:0];
  endfunction

  // Fit a data word (indirect pointer) to the address width
  function automatic logic [ADDR_W-1:0] data_addr(input logic [WIDTH-1:0] d);
    logic [ADDR_W+WIDTH-1:0] t;
    t = {{ADDR_W{1'b0}}, d};
    return t[ADDR_W-1:0];
  endfunction

  logic [3:0]               op;
  logic [1:0]               mode;
  logic [9:0]               opnd;
  logic                     uses_operand;
  logic [WIDTH-1:0]         rhs;
  logic [WIDTH:0]           alu_out;
  logic signed [ADDR_W-1:0] br_off;
  logic                     cond;
  logic [ADDR_W-1:0]        pc_inc;

  assign op           = ir_q[15:12];
  assign mode         = ir_q[11:10];
  assign opnd         = ir_q[9:0];
  assign uses_operand = (op >= OP_LOAD) && (op <= OP_XOR);
  assign rhs          = (state_q == S_OPER) ? mem_rdata : {{(WIDTH-10){1'b0}}, opnd};
  assign alu_out      = alu(op, accum_q, rhs, c_q);
  assign br_off       = {{(ADDR_W-10){opnd[9]}}, opnd};
  assign pc_inc       = pc_q + ADDR_W'(1);

  // IF condition: 0 Z=0, 1 Z=1, 2 C=0, 3 C=1
  always_comb begin
    case (opnd[1:0])
      2'd0:    cond = !z_q;
      2'd1:    cond = z_q;
      2'd2:    cond = !c_q;
      default: cond = c_q;
    endcase
  end

`ifdef ACC_CPU_GEN2_CALL_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  logic [SP_W-1:0]   sp_q, sp_d, sp_m1;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic              push;
  assign sp_m1 = sp_q - SP_W'(1);
`else
  logic unused_depth;
  assign unused_depth = (STACK_DEPTH > 0);
`endif

  // Next-state, datapath and memory-request logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    accum_d     = accum_q;
    z_d         = z_q;
    c_d         = c_q;
    skip_d      = skip_q;
    data_out_d  = data_out_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    ir_d        = ir_q;
`ifdef ACC_CPU_GEN2_CALL_EN
    sp_d        = sp_q;
    push        = 1'b0;
`endif
    case (state_q)
      S_IDLE: if (step || run) begin
        state_d    = S_FETCH;
        mem_req_d  = 1'b1;
        mem_we_d   = 1'b0;
        mem_addr_d = pc_q;
      end
      S_FETCH: if (mem_req_q && mem_ack) begin
        ir_d      = mem_rdata[15:0];
        mem_req_d = 1'b0;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (skip_q) begin
          skip_d  = 1'b0;
          pc_d    = pc_inc;
          state_d = S_IDLE;
        end else if (uses_operand && mode == 2'd3) begin
          state_d = S_TRAP;
        end else begin
          case (op)
            OP_NOP: begin
              pc_d    = pc_inc;
              state_d = S_IDLE;
            end
            OP_LOAD, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: begin
              if (mode == 2'd0) begin
                accum_d = alu_out[WIDTH-1:0];
                c_d     = alu_out[WIDTH];
                z_d     = (alu_out[WIDTH-1:0] == '0);
                pc_d    = pc_inc;
                state_d = S_IDLE;
              end else begin
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = opnd_addr(opnd);
                state_d    = (mode == 2'd1) ? S_OPER : S_PTR;
              end
            end
            OP_STORE: begin
              if (mode == 2'd0) begin
                state_d = S_TRAP;
              end else begin
                mem_req_d   = 1'b1;
                mem_we_d    = (mode == 2'd1);
                mem_addr_d  = opnd_addr(opnd);
                mem_wdata_d = accum_q;
                state_d     = (mode == 2'd1) ? S_WRITE : S_PTR;
              end
            end
            OP_NOT: begin
              accum_d = alu_out[WIDTH-1:0];
              z_d     = (alu_out[WIDTH-1:0] == '0);
              pc_d    = pc_inc;
              state_d = S_IDLE;
            end
            OP_BR: begin
              pc_d    = pc_inc + br_off;
              state_d = S_IDLE;
            end
            OP_IF: begin
              skip_d  = !cond;
              pc_d    = pc_inc;
              state_d = S_IDLE;
            end
            OP_OUT: begin
              data_out_d = accum_q[7:0];
              pc_d       = pc_inc;
              state_d    = S_IDLE;
            end
            OP_HALT: state_d = S_HALT;
`ifdef ACC_CPU_GEN2_CALL_EN
            OP_CALL: begin
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                state_d = S_TRAP;
              end else begin
                push    = 1'b1;
                sp_d    = sp_q + SP_W'(1);
                pc_d    = opnd_addr(opnd);
                state_d = S_IDLE;
              end
            end
            OP_RET: begin
              if (sp_q == '0) begin
                state_d = S_TRAP;
              end else begin
                sp_d    = sp_m1;
                pc_d    = stack_q[sp_m1[IDX_W-1:0]];
                state_d = S_IDLE;
              end
            end
`endif
            default: state_d = S_TRAP;
          endcase
        end
      end
      S_PTR: if (mem_req_q && mem_ack) begin
        mem_req_d  = 1'b0;
        mem_addr_d = data_addr(mem_rdata);
        if (op == OP_STORE) begin
          mem_we_d    = 1'b1;
          mem_wdata_d = accum_q;
          state_d     = S_WRITE;
        end else begin
          state_d = S_OPER;
        end
      end
      S_OPER: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          accum_d   = alu_out[WIDTH-1:0];
          c_d       = alu_out[WIDTH];
          z_d       = (alu_out[WIDTH-1:0] == '0);
          mem_req_d = 1'b0;
          pc_d      = pc_inc;
          state_d   = S_IDLE;
        end
      end
      S_WRITE: begin
        if (!mem_req_q) begin
          mem_req_d = 1'b1;
        end else if (mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          pc_d      = pc_inc;
          state_d   = S_IDLE;
        end
      end
      default: state_d = state_q;
    endcase
  end

  // Architectural state and memory-port registers, cleared asynchronously
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      accum_q     <= '0;
      z_q         <= 1'b0;
      c_q         <= 1'b0;
      skip_q      <= 1'b0;
      data_out_q  <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
`ifdef ACC_CPU_GEN2_CALL_EN
      sp_q        <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      accum_q     <= accum_d;
      z_q         <= z_d;
      c_q         <= c_d;
      skip_q      <= skip_d;
      data_out_q  <= data_out_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef ACC_CPU_GEN2_CALL_EN
      sp_q        <= sp_d;
`endif
    end
  end

  // Instruction register: pure data, always loaded before it is decoded
  always_ff @(posedge clk) begin
    ir_q <= ir_d;
  end

`ifdef ACC_CPU_GEN2_CALL_EN
  // Return stack: push the return address on CALL
  always_ff @(posedge clk) begin
    if (push) stack_q[sp_q[IDX_W-1:0]] <= pc_inc;
  end
`endif

  assign busy      = !(state_q == S_IDLE || state_q == S_HALT || state_q == S_TRAP);
  assign halt      = (state_q == S_HALT);
  assign trap      = (state_q == S_TRAP);
  assign data_out  = data_out_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

endmodule
